// File: rtl/warmboot_sequencer_if.sv
// Bootloader-side signals for the warmboot sequencer: request, image select,
// activity/chip-select status in; SB_WARMBOOT controls and busy out.
interface warmboot_sequencer_if;
   logic       boot_req;
   logic [1:0] boot_image;
   logic       usb_activity;
   logic       spi_cs;
   logic       wb_s1;
   logic       wb_s0;
   logic       wb_boot;
   logic       busy;

   modport master (
      output boot_req, boot_image, usb_activity, spi_cs,
      input  wb_s1, wb_s0, wb_boot, busy
   );

   modport slave (
      input  boot_req, boot_image, usb_activity, spi_cs,
      output wb_s1, wb_s0, wb_boot, busy
   );
endinterface

// File: rtl/warmboot_sequencer.sv
// Sequences SB_WARMBOOT: latch image, wait for SPI idle, hold S1/S0, then BOOT.
// Define WARMBOOT_TIMEOUT_EN to auto-boot DEFAULT_IMAGE after USB inactivity.
module warmboot_sequencer #(
   parameter int unsigned CS_IDLE_CYCLES = 4,
   parameter int unsigned SETUP_CYCLES   = 16,
   parameter int unsigned TIMEOUT_CYCLES = 48_000_000 * 10,
   parameter logic [1:0]  DEFAULT_IMAGE  = 2'b01
) (
   input logic                   clk_48mhz,
   input logic                   reset,
   warmboot_sequencer_if.slave   bus
);

   localparam int unsigned CS_W = $clog2(CS_IDLE_CYCLES) + 1;
   localparam int unsigned SU_W = $clog2(SETUP_CYCLES) + 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SPI = 2'd1,
      SETUP    = 2'd2,
      FIRE     = 2'd3
   } state_t;

   state_t          state;
   logic [1:0]      image;
   logic [CS_W-1:0] cs_cnt;
   logic [SU_W-1:0] su_cnt;
   logic            busy_q;
   logic            boot_q;
   logic            expired_c;

`ifdef WARMBOOT_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [TO_W-1:0] to_cnt;

   // Activity on the expiry cycle wins, so it masks the trigger.
   assign expired_c = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) && !bus.usb_activity;

   // Inactivity timer: runs only while idle, restarted by any bus activity.
   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         to_cnt <= '0;
      end else if (state != IDLE || bus.usb_activity || bus.boot_req || expired_c) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + TO_W'(1);
      end
   end
`else
   logic unused_activity;

   assign expired_c       = 1'b0;
   assign unused_activity = bus.usb_activity;
`endif

   assign bus.wb_s1   = image[1];
   assign bus.wb_s0   = image[0];
   assign bus.wb_boot = boot_q;
   assign bus.busy    = busy_q;

   // Sequencer: image only changes on leaving IDLE, so S1/S0 are frozen through BOOT.
   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         state  <= IDLE;
         image  <= DEFAULT_IMAGE;
         cs_cnt <= '0;
         su_cnt <= '0;
         busy_q <= 1'b0;
         boot_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.boot_req) begin
                  image  <= bus.boot_image;
                  state  <= WAIT_SPI;
                  busy_q <= 1'b1;
               end else if (expired_c) begin
                  image  <= DEFAULT_IMAGE;
                  state  <= WAIT_SPI;
                  busy_q <= 1'b1;
               end
            end
            WAIT_SPI: begin
               if (!bus.spi_cs) begin
                  cs_cnt <= '0;
               end else if (cs_cnt == CS_W'(CS_IDLE_CYCLES - 1)) begin
                  cs_cnt <= '0;
                  su_cnt <= '0;
                  state  <= SETUP;
               end else begin
                  cs_cnt <= cs_cnt + CS_W'(1);
               end
            end
            SETUP: begin
               if (!bus.spi_cs) begin
                  cs_cnt <= '0;
                  su_cnt <= '0;
                  state  <= WAIT_SPI;
               end else if (su_cnt == SU_W'(SETUP_CYCLES - 1)) begin
                  state  <= FIRE;
                  boot_q <= 1'b1;
               end else begin
                  su_cnt <= su_cnt + SU_W'(1);
               end
            end
            FIRE: begin
               boot_q <= 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_warmboot_sequencer.sv
// Directed bench for warmboot_sequencer; the timeout scenario runs only when
// WARMBOOT_TIMEOUT_EN is defined.
module tb_warmboot_sequencer;

   logic clk_48mhz;
   logic reset;
   int   n_cmp;
   int   n_err;

   warmboot_sequencer_if bus ();

   warmboot_sequencer #(
      .CS_IDLE_CYCLES (4),
      .SETUP_CYCLES   (16),
      .TIMEOUT_CYCLES (100),
      .DEFAULT_IMAGE  (2'b01)
   ) dut (
      .clk_48mhz (clk_48mhz),
      .reset     (reset),
      .bus       (bus.slave)
   );

   initial clk_48mhz = 1'b0;
   always #5 clk_48mhz = ~clk_48mhz;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges, leaving time 1 unit past the last edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_48mhz);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_boot"}, 32'(bus.wb_boot), 32'd0);
      check({tag, "_img"}, 32'({bus.wb_s1, bus.wb_s0}), 32'h1);
   endtask

   // Present a request for one edge (edge N); returns just after edge N.
   task automatic request(input logic [1:0] img);
      bus.boot_req   = 1'b1;
      bus.boot_image = img;
      step(1);
      bus.boot_req   = 1'b0;
      bus.boot_image = 2'b00;
   endtask

   initial begin
      n_cmp            = 0;
      n_err            = 0;
      bus.boot_req     = 1'b0;
      bus.boot_image   = 2'b00;
      bus.usb_activity = 1'b0;
      bus.spi_cs       = 1'b1;
      reset            = 1'b1;
      step(3);
      check_idle("rst");
      reset = 1'b0;

      // Idle with chip-select high: nothing happens.
      step(10);
      check_idle("idle10");

      // Basic request, image 10, BOOT at N+21.
      request(2'b10);
      check("req_busy", 32'(bus.busy), 32'd1);
      check("req_img", 32'({bus.wb_s1, bus.wb_s0}), 32'h2);
      check("req_boot_early", 32'(bus.wb_boot), 32'd0);
      step(19);
      check("req_boot_n20", 32'(bus.wb_boot), 32'd0);
      step(1);
      check("req_boot_n21", 32'(bus.wb_boot), 32'd1);
      check("req_img_fire", 32'({bus.wb_s1, bus.wb_s0}), 32'h2);
      step(5);
      check("fire_hold", 32'(bus.wb_boot), 32'd1);
      check("fire_img_hold", 32'({bus.wb_s1, bus.wb_s0}), 32'h2);

      // Reset from FIRE returns to reset values on the next edge.
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check_idle("rst_fire");

      // Flash busy for 30 cycles after the request: BOOT at N+51.
      request(2'b10);
      bus.spi_cs = 1'b0;
      step(30);
      check("spi_busy_wait", 32'(bus.busy), 32'd1);
      check("spi_busy_boot", 32'(bus.wb_boot), 32'd0);
      bus.spi_cs = 1'b1;
      step(19);
      check("spi_boot_n50", 32'(bus.wb_boot), 32'd0);
      step(1);
      check("spi_boot_n51", 32'(bus.wb_boot), 32'd1);
      do_reset();

      // One-cycle chip-select glitch in SETUP restarts the whole wait.
      request(2'b10);
      step(11);
      bus.spi_cs = 1'b0;
      step(1);
      bus.spi_cs = 1'b1;
      step(2);
      request(2'b11);
      check("glitch_img", 32'({bus.wb_s1, bus.wb_s0}), 32'h2);
      step(5);
      check("glitch_boot_n20", 32'(bus.wb_boot), 32'd0);
      step(11);
      check("glitch_boot_n31", 32'(bus.wb_boot), 32'd0);
      step(1);
      check("glitch_boot_n32", 32'(bus.wb_boot), 32'd1);
      check("glitch_img_fire", 32'({bus.wb_s1, bus.wb_s0}), 32'h2);
      do_reset();

      // Reset during SETUP, then a clean request completes in 21 cycles.
      request(2'b11);
      step(7);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check_idle("rst_setup");
      request(2'b00);
      check("after_rst_img", 32'({bus.wb_s1, bus.wb_s0}), 32'h0);
      step(19);
      check("after_rst_n20", 32'(bus.wb_boot), 32'd0);
      step(1);
      check("after_rst_n21", 32'(bus.wb_boot), 32'd1);

`ifdef WARMBOOT_TIMEOUT_EN
      // Activity at cycle 50 pushes expiry to cycle 150; auto-boot image 01.
      do_reset();
      step(49);
      bus.usb_activity = 1'b1;
      step(1);
      bus.usb_activity = 1'b0;
      step(99);
      check("to_no_boot_149", 32'(bus.busy), 32'd0);
      step(1);
      check("to_busy_150", 32'(bus.busy), 32'd1);
      check("to_img", 32'({bus.wb_s1, bus.wb_s0}), 32'h1);
      step(19);
      check("to_boot_n20", 32'(bus.wb_boot), 32'd0);
      step(1);
      check("to_boot_n21", 32'(bus.wb_boot), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/warmboot_sequencer.md
# warmboot_sequencer

Sequences the iCE40 SB_WARMBOOT primitive on behalf of the bootloader. It latches the requested image select and waits for the SPI flash chip-select to be idle. It then holds S1/S0 stable for a setup window before asserting BOOT. It sits between the bootloader core and the warmboot primitive in the board top level, and can optionally auto-boot the user image after a period of USB inactivity.

## Interface
- `CS_IDLE_CYCLES`, default 4: consecutive cycles `spi_cs` must be high before setup begins; must be ≥1.
- `SETUP_CYCLES`, default 16: cycles S1/S0 are held stable before BOOT rises; must be ≥1.
- `TIMEOUT_CYCLES`, default 48_000_000 × 10: inactivity cycles before auto-boot; used only with `WARMBOOT_TIMEOUT_EN`; must be ≥1.
- `DEFAULT_IMAGE`, default 2'b01: image select used for reset state and for auto-boot.
- `clk_48mhz`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `boot_req`  in  1  single-cycle request to warmboot; sampled only in IDLE.
- `boot_image`  in  2  image select {S1,S0}; latched on the same edge as an accepted `boot_req`.
- `usb_activity`  in  1  pulse on any USB bus activity; restarts the inactivity timer.
- `spi_cs`  in  1  flash chip-select as driven to the pin, active low.
- `wb_s1`  out  1  to SB_WARMBOOT S1.
- `wb_s0`  out  1  to SB_WARMBOOT S0.
- `wb_boot`  out  1  to SB_WARMBOOT BOOT.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, WAIT_SPI, SETUP, FIRE.
- Image register: 2 bits, reset to `DEFAULT_IMAGE`. Drives {`wb_s1`,`wb_s0`} directly and changes only on an accepted request.
- IDLE:
  - `boot_req`=1: latch `boot_image` and go to WAIT_SPI.
  - Otherwise, if the timeout has expired (when configured): latch `DEFAULT_IMAGE` and go to WAIT_SPI.
- WAIT_SPI:
  - Idle counter increments each cycle `spi_cs`=1 and clears to 0 on any cycle `spi_cs`=0.
  - Go to SETUP on the cycle the counter reaches `CS_IDLE_CYCLES`-1 with `spi_cs`=1.
- SETUP:
  - Setup counter counts `SETUP_CYCLES` cycles, then the state goes to FIRE.
  - If `spi_cs`=0 in any SETUP cycle: return to WAIT_SPI, clear both counters, keep the image.
- FIRE: `wb_boot`=1 and the state holds until reset. The device reconfigures on the BOOT edge, so FIRE is terminal.
- `boot_req` outside IDLE is ignored and has no queued effect.
- Counter widths: `$clog2` of the respective parameter +1. No wrap: each counter saturates or clears by state.

## Timing
- Reset values: `wb_boot`=0, `busy`=0, {`wb_s1`,`wb_s0`}=`DEFAULT_IMAGE`, state IDLE, all counters 0.
- Request accepted at edge N. Then:
  - `busy`=1 and new S1/S0 are visible from cycle N+1.
  - With `spi_cs` continuously high, `wb_boot` rises at cycle N+1+`CS_IDLE_CYCLES`+`SETUP_CYCLES` (default N+21).
- S1/S0 are stable for at least `SETUP_CYCLES` cycles before `wb_boot` rises and never change while `wb_boot`=1.
- `boot_req` and timeout expiry on the same cycle: `boot_req` wins with its `boot_image`.
- `usb_activity` and expiry on the same cycle: activity wins; the timer clears and no boot occurs.
- Reset asserted mid-sequence: next cycle returns to reset values, including `wb_boot`=0 from FIRE.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `WARMBOOT_TIMEOUT_EN` defined:
  - Inactivity timer counts in IDLE only and clears on `usb_activity` or on leaving IDLE.
  - On reaching `TIMEOUT_CYCLES`-1 it triggers auto-boot of `DEFAULT_IMAGE`.
- Undefined: no timer logic is built; only `boot_req` starts a sequence, and `usb_activity` is unused.

## Test plan
- Reset, then idle 10 cycles with `spi_cs`=1 → `wb_boot`=0, `busy`=0, {S1,S0}=01.
- `boot_req` with `boot_image`=2'b10, `spi_cs`=1 throughout → S1/S0=10 from N+1, `busy`=1, `wb_boot`=1 exactly at N+21.
- Same request with `spi_cs`=0 during cycles N+1..N+30, then high → `wb_boot`=1 at N+31+4+16=N+51.
- `spi_cs` pulses low for one cycle at SETUP cycle 8 → state returns to WAIT_SPI and `wb_boot` is delayed a full 4+16 cycles from the next high; second `boot_req` with image 11 during WAIT_SPI leaves S1/S0=10.
- `WARMBOOT_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100, `usb_activity` at cycle 50 → no boot before cycle 150; auto-boot with S1/S0=01, `wb_boot` at cycle 150+1+20.
- Reset at cycle 3 of SETUP and separately in FIRE → `wb_boot`=0, `busy`=0 next cycle; a new request then completes normally in 21 cycles.
